hvac_sequencer: RTL

HVAC_SEQUENCER -- requirements
Module: hvac_sequencer

---
 rtl/hvac_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/hvac_sequencer.sv
// HVAC heat/cool sequencer: tick-timed dwell FSM with hysteresis, fan run-on
// and a compressor lockout between every call, so heating and cooling never reverse directly.
module hvac_sequencer #(
  parameter int unsigned TICK_DIV = 10000000,
  parameter int unsigned HYST     = 1,
  parameter int unsigned MIN_RUN  = 4,
  parameter int unsigned FAN_TAIL = 2,
  parameter int unsigned MIN_OFF  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] current_temp,
  input  logic [7:0] desired_temp,
  output logic       heat_on,
  output logic       cool_on,
  output logic       fan_on,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_LOCKOUT = 3'd1,
    ST_IDLE    = 3'd2,
    ST_HEAT    = 3'd3,
    ST_COOL    = 3'd4,
    ST_FANRUN  = 3'd5
  } state_t;

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [8:0]  HYST9     = 9'(HYST);

  state_t      cur_state;
  state_t      nxt_state;
  logic [31:0] presc;
  logic [7:0]  timer;
  logic [7:0]  load_val;
  logic        tick;
  logic        dwell_done;
  logic        state_change;
  logic [8:0]  cur9;
  logic [8:0]  des9;

  assign tick         = (presc == TICK_LAST);
  assign state_change = (nxt_state != cur_state);
  // Expire on the tick that takes the timer to zero, so a dwell of N lasts exactly N ticks.
  assign dwell_done   = (timer == 8'd0) || ((timer == 8'd1) && tick);

  // Widened by one bit so adding the hysteresis band can never wrap.
  assign cur9 = {1'b0, current_temp};
  assign des9 = {1'b0, desired_temp};

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= ST_OFF;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves nxt_state unassigned (no latch).
    nxt_state = cur_state;
    if (!enable) begin
      nxt_state = ST_OFF;
    end else begin
      case (cur_state)
        ST_OFF:     nxt_state = ST_LOCKOUT;
        ST_LOCKOUT: if (dwell_done) nxt_state = ST_IDLE;
        ST_IDLE: begin
          if ((cur9 + HYST9) < des9)      nxt_state = ST_HEAT;
          else if (cur9 > (des9 + HYST9)) nxt_state = ST_COOL;
        end
        ST_HEAT:    if (dwell_done && (current_temp >= desired_temp)) nxt_state = ST_FANRUN;
        ST_COOL:    if (dwell_done && (current_temp <= desired_temp)) nxt_state = ST_FANRUN;
        ST_FANRUN:  if (dwell_done) nxt_state = ST_LOCKOUT;
        default:    nxt_state = ST_OFF;
      endcase
    end
  end

  always_comb begin
    load_val = 8'd0;
    case (nxt_state)
      ST_HEAT, ST_COOL: load_val = 8'(MIN_RUN);
      ST_FANRUN:        load_val = 8'(FAN_TAIL);
      ST_LOCKOUT:       load_val = 8'(MIN_OFF);
      default:          load_val = 8'd0;
    endcase
  end

  // Prescaler and dwell timer both restart on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= 32'd0;
      timer <= 8'd0;
    end else if (state_change) begin
      presc <= 32'd0;
      timer <= load_val;
    end else begin
      presc <= tick ? 32'd0 : presc + 32'd1;
      if (tick && (timer != 8'd0)) begin
        timer <= timer - 8'd1;
      end
    end
  end

  always_comb begin
    heat_on = (cur_state == ST_HEAT);
    cool_on = (cur_state == ST_COOL);
    fan_on  = (cur_state == ST_HEAT) || (cur_state == ST_COOL) || (cur_state == ST_FANRUN);
  end

  assign state = cur_state;

endmodule
